pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline: drives enable and flush for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and EX-stage control redirects, and freezes the pipeline while data memory is not ready.
- A wait-timeout FSM halts the core on a hung memory access.
- Saturating counters record stall and flush activity for performance debug.

---
 rtl/pipe_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, EX redirect and memory-wait handling,
// with a wait-timeout halt FSM and saturating stall/flush activity counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_redirect,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StHalt
    } state_e;

    localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             stall_inc, flush_inc;
    logic             memstall, loaduse;

    assign memstall = mem_access & ~mem_ready;
    assign loaduse  = ex_memread & (ex_rd != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

    // Pipeline control: one priority chain shared by RUN and MEM_WAIT.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        halted       = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        if (reset) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (state_q == StHalt) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            halted    = 1'b1;
        end else if (memstall) begin
            // Freeze everything up to EX/MEM; the waiting access drains a bubble into MEM/WB.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
            stall_inc    = 1'b1;
        end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
        end else if (loaduse) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            StRun: begin
                if (memstall) begin
                    state_d = StMemWait;
                    wait_d  = 8'd1;
                end else begin
                    wait_d = 8'd0;
                end
            end
            StMemWait: begin
                // Ready, or a dropped access, both release back to RUN.
                if (!memstall) begin
                    state_d = StRun;
                    wait_d  = 8'd0;
                end else if (wait_q == WaitLast) begin
                    state_d = StHalt;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StHalt: state_d = StHalt;
            default: begin
                state_d = StRun;
                wait_d  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
            wait_q  <= 8'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (stall_inc && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_inc && (flush_q != {CNT_W{1'b1}})) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MAX_WAIT=4, CNT_W=4); expected per-cycle control words
// and counter values are queued when a step is driven and compared at the following negedge.
module tb_pipe_hazard_ctrl;

    localparam int unsigned MaxWait = 4;
    localparam int unsigned CntW    = 4;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl, halted}
    localparam logic [9:0] CtlNorm = 10'b11111_0000_0;
    localparam logic [9:0] CtlMem  = 10'b00001_0001_0;
    localparam logic [9:0] CtlRedir = 10'b11111_1100_0;
    localparam logic [9:0] CtlLu   = 10'b00111_0100_0;
    localparam logic [9:0] CtlHalt = 10'b00000_0000_1;
    localparam logic [9:0] CtlRst  = 10'b00000_1111_0;

    typedef struct packed {
        logic [9:0]      ctl;
        logic [CntW-1:0] sc;
        logic [CntW-1:0] fc;
    } exp_t;

    logic            clk, reset;
    logic [4:0]      id_rs1, id_rs2, ex_rd;
    logic            id_uses_rs1, id_uses_rs2, ex_memread, ex_redirect, mem_access, mem_ready;
    logic            pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic            if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, halted;
    logic [CntW-1:0] stall_cnt, flush_cnt;

    exp_t  exp_q[$];
    string tag_q[$];
    int    errors = 0;
    int    checks = 0;

    pipe_hazard_ctrl #(
        .MAX_WAIT(MaxWait),
        .CNT_W   (CntW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_memread  (ex_memread),
        .ex_redirect (ex_redirect),
        .mem_access  (mem_access),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .if_id_en    (if_id_en),
        .id_ex_en    (id_ex_en),
        .ex_mem_en   (ex_mem_en),
        .mem_wb_en   (mem_wb_en),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .ex_mem_flush(ex_mem_flush),
        .mem_wb_flush(mem_wb_flush),
        .halted      (halted),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic [4:0] rd, input logic mr, input logic rdir,
                          input logic macc, input logic mrdy);
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_uses_rs1 = u1;
        id_uses_rs2 = u2;
        ex_rd       = rd;
        ex_memread  = mr;
        ex_redirect = rdir;
        mem_access  = macc;
        mem_ready   = mrdy;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Queue the expectation for this cycle, then compare at the negedge and advance past the edge.
    task automatic step(input string tag, input logic [9:0] ctl, input int sc, input int fc);
        exp_t  e;
        exp_t  got;
        string t;
        e.ctl = ctl;
        e.sc  = CntW'(sc);
        e.fc  = CntW'(fc);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        got = exp_q.pop_front();
        t   = tag_q.pop_front();
        checks++;
        assert ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
                 ex_mem_flush, mem_wb_flush, halted} === got.ctl)
        else begin
            errors++;
            $error("FAIL %s ctl got=%b exp=%b", t,
                   {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
                    ex_mem_flush, mem_wb_flush, halted}, got.ctl);
        end
        checks++;
        assert (stall_cnt === got.sc)
        else begin
            errors++;
            $error("FAIL %s stall_cnt got=%0d exp=%0d", t, stall_cnt, got.sc);
        end
        checks++;
        assert (flush_cnt === got.fc)
        else begin
            errors++;
            $error("FAIL %s flush_cnt got=%0d exp=%0d", t, flush_cnt, got.fc);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clk);
        #1;
        step("reset_hold", CtlRst, 0, 0);
        reset = 1'b0;
        step("normal", CtlNorm, 0, 0);

        // Load-use via rs2, then the same with ex_rd=0 which must not stall.
        set_in(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step("loaduse_rs2", CtlLu, 0, 0);
        set_in(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("loaduse_x0", CtlNorm, 1, 0);
        idle();
        step("after_x0", CtlNorm, 1, 0);

        // Redirect wins over a simultaneous load-use.
        set_in(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        step("redir_lu", CtlRedir, 1, 0);
        idle();
        step("after_redir", CtlNorm, 1, 1);

        // Three not-ready cycles, then ready.
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("memwait", CtlMem, 1 + i, 1);
        mem_ready = 1'b1;
        step("mem_release", CtlNorm, 4, 1);
        idle();
        step("after_mem", CtlNorm, 4, 1);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("zero_wait", CtlNorm, 4, 1);

        // Redirect held through a memory stall is applied only on the release cycle.
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("mem_redir0", CtlMem, 4, 1);
        step("mem_redir1", CtlMem, 5, 1);
        mem_ready = 1'b1;
        step("redir_release", CtlRedir, 6, 1);
        idle();
        step("after_redir2", CtlNorm, 6, 2);

        // Timeout: clear counters, then four not-ready cycles halt the core.
        reset = 1'b1;
        step("reset_mid", CtlRst, 6, 2);
        reset = 1'b0;
        step("post_reset", CtlNorm, 0, 0);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step("timeout_wait", CtlMem, i, 0);
        step("halt", CtlHalt, 4, 0);
        set_in(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        step("halt_frozen", CtlHalt, 4, 0);
        step("halt_frozen2", CtlHalt, 4, 0);
        reset = 1'b1;
        step("halt_reset", CtlRst, 4, 0);
        reset = 1'b0;
        idle();
        step("post_halt", CtlNorm, 0, 0);

        // Saturation of the 4-bit stall counter via rs1 load-use.
        set_in(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("sat_lu", CtlLu, (i < 15) ? i : 15, 0);
        idle();
        step("sat_end", CtlNorm, 15, 0);
        reset = 1'b1;
        step("final_reset", CtlRst, 15, 0);
        step("final_reset2", CtlRst, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
